axi4lite_htif_console: RTL and testbench

Parametrised HTIF console endpoint on an AXI4-Lite slave port, providing buffered, blocking character output plus the input, status and exit functions that the earlier print-only tohost device does not have. The guest writes tohost commands; output characters drain through a TX FIFO to a byte stream, and input bytes arrive through an RX FIFO and are returned via fromhost. It sits on the peripheral interconnect and is used in simulation and on FPGA.

---
 rtl/axi4lite_htif_console_if.sv | 35 +++
 rtl/axi4lite_htif_console.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_axi4lite_htif_console.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_htif_console_if.sv
// AXI4-Lite bus bundle (64-bit data) shared by the HTIF console and its bus master.
// aclk/aresetn travel with the bundle for the owner of the bus; the console uses its own ports.
interface axi4lite_if #(
  parameter int unsigned ALEN = 32
) ();
  logic            aclk;
  logic            aresetn;
  logic            awvalid;
  logic            awready;
  logic [ALEN-1:0] awaddr;
  logic            wvalid;
  logic            wready;
  logic [63:0]     wdata;
  logic [7:0]      wstrb;
  logic            bvalid;
  logic            bready;
  logic [1:0]      bresp;
  logic            arvalid;
  logic            arready;
  logic [ALEN-1:0] araddr;
  logic            rvalid;
  logic            rready;
  logic [63:0]     rdata;
  logic [1:0]      rresp;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport master (
    output aclk, aresetn, awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4lite_htif_console.sv
// HTIF console on an AXI4-Lite slave: tohost commands feed a TX byte FIFO, getchar drains
// an RX byte FIFO into fromhost, and an exit command latches a sticky exit code.
module axi4lite_htif_console #(
  parameter int unsigned    ALEN      = 32,
  parameter logic [ALEN-1:0] ADDR_MASK = {ALEN{1'b1}},
  parameter int unsigned    TX_DEPTH  = 16,
  parameter int unsigned    RX_DEPTH  = 16
) (
  input  logic        aclk,
  input  logic        areset,
  axi4lite_if.slave   bus,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        exit_valid,
  output logic [46:0] exit_code
);

  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned TX_CW = TX_AW + 1;
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned RX_CW = RX_AW + 1;

  localparam logic [ALEN-1:0] ADDR_TOHOST   = '0;
  localparam logic [ALEN-1:0] ADDR_FROMHOST = ALEN'(8);
  localparam logic [ALEN-1:0] ADDR_STATUS   = ALEN'(16);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_STALL,
    W_RESP
  } wstate_t;

  wstate_t     wstate_q, wstate_d;
  logic        awready_q, awready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [7:0]  pend_char_q, pend_char_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [63:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        exit_valid_q, exit_valid_d;
  logic [46:0] exit_code_q, exit_code_d;
  logic [63:0] fromhost_q, fromhost_d;

  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [TX_CW-1:0] tx_count_q, tx_count_d;
  logic             tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]       tx_push_data;

  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [RX_CW-1:0] rx_count_q, rx_count_d;
  logic             rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]       rx_head;

  logic [ALEN-1:0] w_addr, r_addr;
  logic [7:0]      w_dev, w_cmd;
  logic            aw_hs, ar_hs;
  logic [63:0]     status;

  assign tx_full  = (tx_count_q == TX_CW'(TX_DEPTH));
  assign tx_empty = (tx_count_q == '0);
  assign tx_pop   = !tx_empty && tx_ready;
  assign rx_full  = (rx_count_q == RX_CW'(RX_DEPTH));
  assign rx_empty = (rx_count_q == '0);
  assign rx_push  = rx_valid && !rx_full;
  assign rx_head  = rx_mem[rx_rd_ptr_q];

  assign w_addr = bus.awaddr & ADDR_MASK;
  assign r_addr = bus.araddr & ADDR_MASK;
  assign w_dev  = bus.wdata[63:56];
  assign w_cmd  = bus.wdata[55:48];
  assign aw_hs  = awready_q && bus.awvalid && bus.wvalid;
  assign ar_hs  = arready_q && bus.arvalid;

  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_count_d  = tx_count_q;
    if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + TX_AW'(1);
    if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + TX_AW'(1);
    case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + TX_CW'(1);
      2'b01:   tx_count_d = tx_count_q - TX_CW'(1);
      default: tx_count_d = tx_count_q;
    endcase
  end

  always_comb begin
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_count_d  = rx_count_q;
    if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + RX_AW'(1);
    if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + RX_AW'(1);
    case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + RX_CW'(1);
      2'b01:   rx_count_d = rx_count_q - RX_CW'(1);
      default: rx_count_d = rx_count_q;
    endcase
  end

  // FIFO storage is not reset; the pointers and counts alone define the contents.
  always_ff @(posedge aclk) begin
    if (tx_push) tx_mem[tx_wr_ptr_q] <= tx_push_data;
    if (rx_push) rx_mem[rx_wr_ptr_q] <= rx_data;
  end

  always_comb begin
    wstate_d     = wstate_q;
    awready_d    = 1'b0;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    pend_char_d  = pend_char_q;
    fromhost_d   = fromhost_q;
    exit_valid_d = exit_valid_q;
    exit_code_d  = exit_code_q;
    tx_push      = 1'b0;
    tx_push_data = pend_char_q;
    rx_pop       = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs) begin
          wstate_d = W_RESP;
          bvalid_d = 1'b1;
          bresp_d  = RESP_OKAY;
          if (w_addr == ADDR_TOHOST) begin
            if (bus.wstrb != 8'hFF) begin
              bresp_d = RESP_SLVERR;
            end else if (w_dev == 8'd1 && w_cmd == 8'd1) begin
              // A full TX parks the character until a slot frees up.
              if (tx_full) begin
                pend_char_d = bus.wdata[7:0];
                bvalid_d    = 1'b0;
                wstate_d    = W_STALL;
              end else begin
                tx_push      = 1'b1;
                tx_push_data = bus.wdata[7:0];
              end
            end else if (w_dev == 8'd1 && w_cmd == 8'd0) begin
              if (fromhost_q != '0) begin
                bresp_d = RESP_SLVERR;
              end else if (rx_empty) begin
                fromhost_d = {8'h01, 8'h00, 48'hFFFF_FFFF_FFFF};
              end else begin
                fromhost_d = {8'h01, 8'h00, 40'h0, rx_head};
                rx_pop     = 1'b1;
              end
            end else if (w_dev == 8'd0 && w_cmd == 8'd0 && bus.wdata[0]) begin
              if (!exit_valid_q) begin
                exit_valid_d = 1'b1;
                exit_code_d  = bus.wdata[47:1];
              end
            end else begin
              bresp_d = RESP_SLVERR;
            end
          end else if (w_addr == ADDR_FROMHOST) begin
            if (bus.wstrb != 8'hFF) bresp_d = RESP_SLVERR;
            else                    fromhost_d = bus.wdata;
          end else if (w_addr == ADDR_STATUS) begin
            bresp_d = RESP_SLVERR;
          end else begin
            bresp_d = RESP_DECERR;
          end
        end else if (bus.awvalid && bus.wvalid && !awready_q) begin
          awready_d = 1'b1;
        end
      end
      W_STALL: begin
        if (!tx_full) begin
          tx_push  = 1'b1;
          bvalid_d = 1'b1;
          bresp_d  = RESP_OKAY;
          wstate_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bus.bready) begin
          bvalid_d = 1'b0;
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    status        = '0;
    status[0]     = tx_full;
    status[1]     = tx_empty;
    status[2]     = rx_empty;
    status[3]     = (fromhost_q != '0);
    status[23:8]  = 16'(tx_count_q);
    status[47:32] = 16'(rx_count_q);
  end

  // Read data is captured from current register state at the AR handshake.
  always_comb begin
    arready_d = bus.arvalid && !arready_q && (!rvalid_q || bus.rready);
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = RESP_OKAY;
      rdata_d  = '0;
      if (r_addr == ADDR_FROMHOST)      rdata_d = fromhost_q;
      else if (r_addr == ADDR_STATUS)   rdata_d = status;
      else if (r_addr != ADDR_TOHOST)   rresp_d = RESP_DECERR;
    end else if (rvalid_q && bus.rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wstate_q     <= W_IDLE;
      awready_q    <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= 2'b00;
      pend_char_q  <= 8'h00;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      rresp_q      <= 2'b00;
      exit_valid_q <= 1'b0;
      exit_code_q  <= '0;
      fromhost_q   <= '0;
      tx_wr_ptr_q  <= '0;
      tx_rd_ptr_q  <= '0;
      tx_count_q   <= '0;
      rx_wr_ptr_q  <= '0;
      rx_rd_ptr_q  <= '0;
      rx_count_q   <= '0;
    end else begin
      wstate_q     <= wstate_d;
      awready_q    <= awready_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      pend_char_q  <= pend_char_d;
      arready_q    <= arready_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      exit_valid_q <= exit_valid_d;
      exit_code_q  <= exit_code_d;
      fromhost_q   <= fromhost_d;
      tx_wr_ptr_q  <= tx_wr_ptr_d;
      tx_rd_ptr_q  <= tx_rd_ptr_d;
      tx_count_q   <= tx_count_d;
      rx_wr_ptr_q  <= rx_wr_ptr_d;
      rx_rd_ptr_q  <= rx_rd_ptr_d;
      rx_count_q   <= rx_count_d;
    end
  end

  assign bus.awready = awready_q;
  assign bus.wready  = awready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;

  assign tx_valid   = !tx_empty;
  assign tx_data    = tx_mem[tx_rd_ptr_q];
  assign rx_ready   = !rx_full;
  assign exit_valid = exit_valid_q;
  assign exit_code  = exit_code_q;

endmodule

// File: tb/tb_axi4lite_htif_console.sv
// Self-checking bench for axi4lite_htif_console: register-map vector tables plus
// hand-written getchar, TX back-pressure and reset-during-stall sequences.
module tb_axi4lite_htif_console;

  localparam int ALEN    = 32;
  localparam int TIMEOUT = 50;

  logic        aclk = 1'b0;
  logic        areset;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;
  logic        rx_valid, rx_ready;
  logic [7:0]  rx_data;
  logic        exit_valid;
  logic [46:0] exit_code;

  axi4lite_if #(.ALEN(ALEN)) bus_if ();
  assign bus_if.aclk    = aclk;
  assign bus_if.aresetn = !areset;

  axi4lite_htif_console #(
    .ALEN     (ALEN),
    .TX_DEPTH (4),
    .RX_DEPTH (4)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .bus        (bus_if),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .exit_valid (exit_valid),
    .exit_code  (exit_code)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    bit          is_write;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [1:0]  resp;
    logic [63:0] rdata;
  } vec_t;

  typedef struct {
    logic [1:0]  resp;
    logic [63:0] rdata;
    bit          chk_data;
  } exp_t;

  vec_t       vecs[$];
  exp_t       exp_q[$];
  logic [7:0] tx_exp[$];
  logic [7:0] tx_got[$];
  int         n_checks = 0;
  int         n_errors = 0;

  // TX stream monitor: inputs move on negedge, so a transfer seen here lands on the next posedge.
  always begin
    @(negedge aclk);
    #2;
    if (!areset && tx_valid && tx_ready) tx_got.push_back(tx_data);
  end

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkLe(input string name, input int act, input int maxv);
    n_checks++;
    if (act > maxv) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected <= %0d", name, act, maxv);
    end
  endtask

  task automatic timeoutFail(input string name);
    n_checks++;
    n_errors++;
    $display("[TB] FAIL %s: timed out after %0d cycles", name, TIMEOUT);
  endtask

  task automatic axiWrite(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb,
                          output logic [1:0] resp, output int lat);
    int n;
    resp = 2'bxx;
    @(negedge aclk);
    bus_if.awaddr  = addr;
    bus_if.wdata   = data;
    bus_if.wstrb   = strb;
    bus_if.awvalid = 1'b1;
    bus_if.wvalid  = 1'b1;
    @(negedge aclk);
    n = 1;
    while (!bus_if.awready && n < TIMEOUT) begin
      @(negedge aclk);
      n++;
    end
    if (!bus_if.awready) begin
      timeoutFail("aw_handshake");
      bus_if.awvalid = 1'b0;
      bus_if.wvalid  = 1'b0;
      lat = n;
      return;
    end
    @(negedge aclk);
    n++;
    bus_if.awvalid = 1'b0;
    bus_if.wvalid  = 1'b0;
    bus_if.bready  = 1'b1;
    while (!bus_if.bvalid && n < TIMEOUT) begin
      @(negedge aclk);
      n++;
    end
    lat = n;
    if (!bus_if.bvalid) begin
      timeoutFail("b_response");
      bus_if.bready = 1'b0;
      return;
    end
    resp = bus_if.bresp;
    @(negedge aclk);
    bus_if.bready = 1'b0;
  endtask

  task automatic axiRead(input logic [31:0] addr, output logic [63:0] data, output logic [1:0] resp);
    int n;
    data = 'x;
    resp = 2'bxx;
    @(negedge aclk);
    bus_if.araddr  = addr;
    bus_if.arvalid = 1'b1;
    @(negedge aclk);
    n = 1;
    while (!bus_if.arready && n < TIMEOUT) begin
      @(negedge aclk);
      n++;
    end
    if (!bus_if.arready) begin
      timeoutFail("ar_handshake");
      bus_if.arvalid = 1'b0;
      return;
    end
    @(negedge aclk);
    bus_if.arvalid = 1'b0;
    bus_if.rready  = 1'b1;
    while (!bus_if.rvalid && n < TIMEOUT) begin
      @(negedge aclk);
      n++;
    end
    if (!bus_if.rvalid) begin
      timeoutFail("r_response");
      bus_if.rready = 1'b0;
      return;
    end
    data = bus_if.rdata;
    resp = bus_if.rresp;
    @(negedge aclk);
    bus_if.rready = 1'b0;
  endtask

  task automatic addVec(input bit is_write, input logic [31:0] addr, input logic [63:0] data,
                        input logic [7:0] strb, input logic [1:0] resp, input logic [63:0] rdata);
    vec_t v;
    v.is_write = is_write;
    v.addr     = addr;
    v.data     = data;
    v.strb     = strb;
    v.resp     = resp;
    v.rdata    = rdata;
    vecs.push_back(v);
  endtask

  // Queues the expected response (and any TX byte an accepted putchar should emit), then drives it.
  task automatic applyStimulus(input vec_t v, output logic [1:0] resp, output logic [63:0] rd);
    exp_t e;
    int   lat;
    e.resp     = v.resp;
    e.rdata    = v.rdata;
    e.chk_data = !v.is_write;
    exp_q.push_back(e);
    rd = '0;
    if (v.is_write) begin
      if (v.addr == 32'h0 && v.strb == 8'hFF && v.data[63:48] == 16'h0101 && v.resp == 2'b00)
        tx_exp.push_back(v.data[7:0]);
      axiWrite(v.addr, v.data, v.strb, resp, lat);
    end else begin
      axiRead(v.addr, rd, resp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [1:0] resp, input logic [63:0] rd);
    exp_t e;
    e = exp_q.pop_front();
    checkVal({name, "_resp"}, 64'(resp), 64'(e.resp));
    if (e.chk_data) checkVal({name, "_rdata"}, rd, e.rdata);
  endtask

  task automatic runVecs(input string tag);
    logic [1:0]  r;
    logic [63:0] d;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], r, d);
      checkOutput($sformatf("%s%0d", tag, i), r, d);
    end
    vecs.delete();
  endtask

  task automatic checkTx(input string tag);
    int n;
    checkVal({tag, "_tx_len"}, 64'(tx_got.size()), 64'(tx_exp.size()));
    n = (tx_got.size() < tx_exp.size()) ? tx_got.size() : tx_exp.size();
    for (int i = 0; i < n; i++) checkVal($sformatf("%s_tx%0d", tag, i), 64'(tx_got[i]), 64'(tx_exp[i]));
    tx_got.delete();
    tx_exp.delete();
  endtask

  task automatic pushRx(input logic [7:0] b);
    @(negedge aclk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge aclk);
    rx_valid = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkVal({tag, "_awready"}, 64'(bus_if.awready), 64'h0);
    checkVal({tag, "_wready"}, 64'(bus_if.wready), 64'h0);
    checkVal({tag, "_bvalid"}, 64'(bus_if.bvalid), 64'h0);
    checkVal({tag, "_bresp"}, 64'(bus_if.bresp), 64'h0);
    checkVal({tag, "_arready"}, 64'(bus_if.arready), 64'h0);
    checkVal({tag, "_rvalid"}, 64'(bus_if.rvalid), 64'h0);
    checkVal({tag, "_rresp"}, 64'(bus_if.rresp), 64'h0);
    checkVal({tag, "_rdata"}, bus_if.rdata, 64'h0);
    checkVal({tag, "_exit_valid"}, 64'(exit_valid), 64'h0);
    checkVal({tag, "_exit_code"}, 64'(exit_code), 64'h0);
    checkVal({tag, "_tx_valid"}, 64'(tx_valid), 64'h0);
    checkVal({tag, "_rx_ready"}, 64'(rx_ready), 64'h1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  r;
    logic [63:0] d;
    int          lat;
    int          k;

    areset         = 1'b1;
    tx_ready       = 1'b1;
    rx_valid       = 1'b0;
    rx_data        = 8'h00;
    bus_if.awvalid = 1'b0;
    bus_if.awaddr  = '0;
    bus_if.wvalid  = 1'b0;
    bus_if.wdata   = '0;
    bus_if.wstrb   = '0;
    bus_if.bready  = 1'b0;
    bus_if.arvalid = 1'b0;
    bus_if.araddr  = '0;
    bus_if.rready  = 1'b0;
    repeat (3) @(negedge aclk);
    checkResetOutputs("rst");
    areset = 1'b0;

    $display("[TB] register map vectors");
    addVec(1, 32'h00, 64'h0101_0000_0000_0041, 8'hFF, 2'b00, 64'h0);
    addVec(0, 32'h10, 64'h0, 8'h00, 2'b00, 64'h6);
    addVec(1, 32'h00, 64'h0101_0000_0000_0042, 8'h0F, 2'b10, 64'h0);
    addVec(1, 32'h00, 64'h0200_0000_0000_0000, 8'hFF, 2'b10, 64'h0);
    addVec(1, 32'h00, 64'h0102_0000_0000_0043, 8'hFF, 2'b10, 64'h0);
    addVec(1, 32'h00, 64'h0000_0000_0000_0006, 8'hFF, 2'b10, 64'h0);
    addVec(0, 32'h18, 64'h0, 8'h00, 2'b11, 64'h0);
    addVec(0, 32'h00, 64'h0, 8'h00, 2'b00, 64'h0);
    addVec(1, 32'h10, 64'h0000_0000_0000_00FF, 8'hFF, 2'b10, 64'h0);
    addVec(1, 32'h20, 64'h0, 8'hFF, 2'b11, 64'h0);
    addVec(1, 32'h08, 64'h0000_0000_0000_1234, 8'hFF, 2'b00, 64'h0);
    addVec(0, 32'h08, 64'h0, 8'h00, 2'b00, 64'h1234);
    addVec(0, 32'h10, 64'h0, 8'h00, 2'b00, 64'hE);
    addVec(1, 32'h08, 64'h0, 8'hFE, 2'b10, 64'h0);
    addVec(0, 32'h08, 64'h0, 8'h00, 2'b00, 64'h1234);
    addVec(1, 32'h08, 64'h0, 8'hFF, 2'b00, 64'h0);
    addVec(1, 32'h00, 64'h0000_0000_0000_0007, 8'hFF, 2'b00, 64'h0);
    addVec(1, 32'h00, 64'h0000_0000_0000_000B, 8'hFF, 2'b00, 64'h0);
    addVec(0, 32'h10, 64'h0, 8'h00, 2'b00, 64'h6);
    runVecs("map");
    checkVal("exit_valid", 64'(exit_valid), 64'h1);
    checkVal("exit_code", 64'(exit_code), 64'h3);
    repeat (4) @(negedge aclk);
    checkTx("map");

    $display("[TB] getchar sequence");
    pushRx(8'h55);
    addVec(0, 32'h10, 64'h0, 8'h00, 2'b00, 64'h0000_0001_0000_0002);
    addVec(1, 32'h00, 64'h0100_0000_0000_0000, 8'hFF, 2'b00, 64'h0);
    addVec(0, 32'h08, 64'h0, 8'h00, 2'b00, 64'h0100_0000_0000_0055);
    addVec(0, 32'h10, 64'h0, 8'h00, 2'b00, 64'hE);
    addVec(1, 32'h00, 64'h0100_0000_0000_0000, 8'hFF, 2'b10, 64'h0);
    addVec(1, 32'h08, 64'h0, 8'hFF, 2'b00, 64'h0);
    addVec(1, 32'h00, 64'h0100_0000_0000_0000, 8'hFF, 2'b00, 64'h0);
    addVec(0, 32'h08, 64'h0, 8'h00, 2'b00, 64'h0100_FFFF_FFFF_FFFF);
    addVec(1, 32'h08, 64'h0, 8'hFF, 2'b00, 64'h0);
    runVecs("getc");

    $display("[TB] TX back-pressure");
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tx_exp.push_back(8'h61 + 8'(i));
      axiWrite(32'h00, {56'h0101_0000_0000_00, 8'h61 + 8'(i)}, 8'hFF, r, lat);
      checkVal($sformatf("fill%0d_resp", i), 64'(r), 64'h0);
      checkLe($sformatf("fill%0d_latency", i), lat, 3);
    end
    axiRead(32'h10, d, r);
    checkVal("full_status", d, 64'h405);
    tx_exp.push_back(8'h65);
    fork
      begin
        axiWrite(32'h00, 64'h0101_0000_0000_0065, 8'hFF, r, lat);
        checkVal("stall_resp", 64'(r), 64'h0);
      end
      begin
        repeat (10) @(negedge aclk);
        checkVal("stall_no_bvalid", 64'(bus_if.bvalid), 64'h0);
        tx_ready = 1'b1;
        @(negedge aclk);
        tx_ready = 1'b0;
        k = 1;
        while (!bus_if.bvalid && k < 10) begin
          @(negedge aclk);
          k++;
        end
        checkLe("stall_release_latency", k, 2);
      end
    join
    tx_ready = 1'b1;
    repeat (10) @(negedge aclk);
    checkTx("stall");

    $display("[TB] reset during stall");
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      axiWrite(32'h00, {56'h0101_0000_0000_00, 8'h70 + 8'(i)}, 8'hFF, r, lat);
    end
    for (int i = 0; i < 3; i++) pushRx(8'h30 + 8'(i));
    axiRead(32'h10, d, r);
    checkVal("prerst_status", d, 64'h0000_0003_0000_0401);
    @(negedge aclk);
    bus_if.awaddr  = 32'h00;
    bus_if.wdata   = 64'h0101_0000_0000_0078;
    bus_if.wstrb   = 8'hFF;
    bus_if.awvalid = 1'b1;
    bus_if.wvalid  = 1'b1;
    k = 0;
    while (!bus_if.awready && k < TIMEOUT) begin
      @(negedge aclk);
      k++;
    end
    if (!bus_if.awready) timeoutFail("stall5_aw_handshake");
    @(negedge aclk);
    bus_if.awvalid = 1'b0;
    bus_if.wvalid  = 1'b0;
    bus_if.bready  = 1'b1;
    repeat (3) @(negedge aclk);
    checkVal("stall5_no_bvalid", 64'(bus_if.bvalid), 64'h0);
    areset = 1'b1;
    #1;
    checkResetOutputs("midrst");
    bus_if.bready = 1'b0;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    axiRead(32'h10, d, r);
    checkVal("postrst_status", d, 64'h6);
    axiRead(32'h08, d, r);
    checkVal("postrst_fromhost", d, 64'h0);
    checkVal("postrst_tx_valid", 64'(tx_valid), 64'h0);
    repeat (3) @(negedge aclk);
    checkVal("postrst_no_tx", 64'(tx_got.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
